// File: rtl/bsg_manycore_pkg.sv
// rtl/bsg_manycore_pkg.sv - manycore packet op/return enums, reg_id widths and arbiter tag helper
package bsg_manycore_pkg;

  localparam int bsg_manycore_reg_id_width_gp  = 5;
  localparam int bsg_manycore_arb_tag_width_gp = 3;

  typedef enum logic [1:0] {
    e_remote_load  = 2'd0,
    e_remote_store = 2'd1,
    e_remote_amo   = 2'd2,
    e_cache_op     = 2'd3
  } bsg_manycore_packet_op_e;

  typedef enum logic [1:0] {
    e_return_credit    = 2'd0,
    e_return_int_wb    = 2'd1,
    e_return_float_wb  = 2'd2,
    e_return_ifetch    = 2'd3
  } bsg_manycore_return_packet_type_e;

  // Requester index lives in the upper lg_num_req bits of reg_id (1 <= lg_num_req <= tag width).
  function automatic logic [bsg_manycore_arb_tag_width_gp-1:0] bsg_manycore_arb_tag
    (input logic [bsg_manycore_reg_id_width_gp-1:0] reg_id, input int lg_num_req);
    logic [bsg_manycore_reg_id_width_gp-1:0] shifted;
    shifted = reg_id >> (bsg_manycore_reg_id_width_gp - lg_num_req);
    return shifted[bsg_manycore_arb_tag_width_gp-1:0];
  endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// rtl/bsg_arb_round_robin.sv - round-robin grant select; pointer advances past the winner on yumi
module bsg_arb_round_robin #(
  parameter  int width_p     = 4,
  localparam int lg_width_lp = (width_p > 1) ? $clog2(width_p) : 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [width_p-1:0]     reqs_i,
  output logic                   v_o,
  output logic [lg_width_lp-1:0] tag_o,
  input  logic                   yumi_i
);

  logic [lg_width_lp-1:0] rr_ptr;
  logic [lg_width_lp-1:0] idx;

  // width_p is a power of two, so pointer arithmetic wraps naturally.
  always_comb begin
    v_o   = 1'b0;
    tag_o = '0;
    idx   = '0;
    for (int i = 0; i < width_p; i++) begin
      idx = rr_ptr + lg_width_lp'(i);
      if (!v_o && reqs_i[idx]) begin
        v_o   = 1'b1;
        tag_o = idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)
      rr_ptr <= '0;
    else if (yumi_i)
      rr_ptr <= tag_o + 1'b1;
  end

endmodule

// File: rtl/bsg_counter_up_down.sv
// rtl/bsg_counter_up_down.sv - saturation-checked up/down occupancy counter
module bsg_counter_up_down #(
  parameter  int max_val_p = 16,
  localparam int width_lp  = $clog2(max_val_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                up_i,
  input  logic                down_i,
  output logic [width_lp-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i)
      count_o <= '0;
    else if (up_i && !down_i)
      count_o <= count_o + 1'b1;
    else if (down_i && !up_i)
      count_o <= count_o - 1'b1;
  end

  always @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(up_i && !down_i && count_o == width_lp'(max_val_p)))
        else $error("bsg_counter_up_down: overflow");
      assert (!(down_i && !up_i && count_o == '0))
        else $error("bsg_counter_up_down: underflow");
    end
  end

endmodule

// File: rtl/bsg_priority_encode.sv
// rtl/bsg_priority_encode.sv - lowest-index-wins encoder, built only with BSG_MANYCORE_OUT_ARB_FIXED_PRIO_EN
`ifdef BSG_MANYCORE_OUT_ARB_FIXED_PRIO_EN
module bsg_priority_encode #(
  parameter  int width_p     = 4,
  localparam int lg_width_lp = (width_p > 1) ? $clog2(width_p) : 1
) (
  input  logic [width_p-1:0]     i,
  output logic [lg_width_lp-1:0] addr_o,
  output logic                   v_o
);

  always_comb begin
    addr_o = '0;
    v_o    = 1'b0;
    for (int k = width_p - 1; k >= 0; k--) begin
      if (i[k]) begin
        addr_o = lg_width_lp'(k);
        v_o    = 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/bsg_manycore_endpoint_out_arbiter.sv
// rtl/bsg_manycore_endpoint_out_arbiter.sv - shares one endpoint master port among requesters with credit/load limits
// BSG_MANYCORE_OUT_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module bsg_manycore_endpoint_out_arbiter
  import bsg_manycore_pkg::*;
#(
  parameter  int num_req_p           = 4,
  parameter  int x_cord_width_p      = 4,
  parameter  int y_cord_width_p      = 4,
  parameter  int addr_width_p        = 32,
  parameter  int data_width_p        = 32,
  parameter  int max_out_credits_p   = 16,
  parameter  int max_loads_per_req_p = 4,
  localparam int lg_num_req_lp       = $clog2(num_req_p),
  localparam int tag_lsb_lp          = bsg_manycore_reg_id_width_gp - lg_num_req_lp,
  localparam int credit_width_lp     = $clog2(max_out_credits_p + 1),
  localparam int load_width_lp       = $clog2(max_loads_per_req_p + 1),
  localparam int packet_width_lp     = addr_width_p + $bits(bsg_manycore_packet_op_e)
                                       + bsg_manycore_reg_id_width_gp + data_width_p
                                       + 2 * (x_cord_width_p + y_cord_width_p)
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,

  input  logic [num_req_p-1:0]                    req_v_i,
  input  logic [num_req_p*packet_width_lp-1:0]    req_packet_i,
  output logic [num_req_p-1:0]                    req_yumi_o,

  output logic                                    out_v_o,
  output logic [packet_width_lp-1:0]              out_packet_o,
  input  logic                                    out_ready_i,

  input  logic                                    returned_v_i,
  input  logic [data_width_p-1:0]                 returned_data_i,
  input  logic [bsg_manycore_reg_id_width_gp-1:0] returned_reg_id_i,
  input  bsg_manycore_return_packet_type_e        returned_pkt_type_i,
  output logic                                    returned_yumi_o,
  input  logic                                    returned_credit_v_i,

  output logic [num_req_p-1:0]                    resp_v_o,
  output logic [data_width_p-1:0]                 resp_data_o,
  output logic [bsg_manycore_reg_id_width_gp-1:0] resp_reg_id_o,
  input  logic [num_req_p-1:0]                    resp_yumi_i,

  output logic [credit_width_lp-1:0]              credits_used_o,
  output logic                                    idle_o
);

  typedef struct packed {
    logic [addr_width_p-1:0]                  addr;
    bsg_manycore_packet_op_e                  op_v2;
    logic [bsg_manycore_reg_id_width_gp-1:0]  reg_id;
    logic [data_width_p-1:0]                  payload;
    logic [y_cord_width_p-1:0]                src_y_cord;
    logic [x_cord_width_p-1:0]                src_x_cord;
    logic [y_cord_width_p-1:0]                y_cord;
    logic [x_cord_width_p-1:0]                x_cord;
  } packet_s;

  packet_s                    req_pkt [num_req_p];
  logic [load_width_lp-1:0]   load_cnt [num_req_p];
  logic [num_req_p-1:0]       is_load, load_full, eligible, load_up, load_down;
  logic [credit_width_lp-1:0] credits_used;
  logic                       credits_full, grant_v, handshake, loads_zero;
  logic [lg_num_req_lp-1:0]   grant_id, resp_id;
  packet_s                    out_pkt;

  // Eligibility looks only at registered counts: a same-cycle return never frees a slot.
  assign credits_full = (credits_used >= credit_width_lp'(max_out_credits_p));

  for (genvar i = 0; i < num_req_p; i++) begin : g_req
    assign req_pkt[i]   = packet_s'(req_packet_i[i*packet_width_lp +: packet_width_lp]);
    assign is_load[i]   = (req_pkt[i].op_v2 == e_remote_load);
    assign load_full[i] = (load_cnt[i] >= load_width_lp'(max_loads_per_req_p));
    assign eligible[i]  = ~reset_i & req_v_i[i] & ~credits_full & ~(is_load[i] & load_full[i]);
    assign load_up[i]   = req_yumi_o[i] & is_load[i];
    assign load_down[i] = resp_v_o[i] & resp_yumi_i[i];

    bsg_counter_up_down #(.max_val_p(max_loads_per_req_p)) load_ctr (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .up_i    (load_up[i]),
      .down_i  (load_down[i]),
      .count_o (load_cnt[i])
    );
  end

`ifdef BSG_MANYCORE_OUT_ARB_FIXED_PRIO_EN
  bsg_priority_encode #(.width_p(num_req_p)) grant_sel (
    .i      (eligible),
    .addr_o (grant_id),
    .v_o    (grant_v)
  );
`else
  bsg_arb_round_robin #(.width_p(num_req_p)) grant_sel (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .reqs_i  (eligible),
    .v_o     (grant_v),
    .tag_o   (grant_id),
    .yumi_i  (handshake)
  );
`endif

  always_comb begin
    out_pkt = req_pkt[grant_id];
    if (is_load[grant_id])
      out_pkt.reg_id[bsg_manycore_reg_id_width_gp-1 -: lg_num_req_lp] = grant_id;
  end

  assign out_v_o      = grant_v;
  assign out_packet_o = out_pkt;
  assign handshake    = out_v_o & out_ready_i;
  assign req_yumi_o   = handshake ? (num_req_p'(1) << grant_id) : '0;

  bsg_counter_up_down #(.max_val_p(max_out_credits_p)) credit_ctr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .up_i    (handshake),
    .down_i  (returned_credit_v_i),
    .count_o (credits_used)
  );

  assign resp_id         = lg_num_req_lp'(bsg_manycore_arb_tag(returned_reg_id_i, lg_num_req_lp));
  assign resp_v_o        = (returned_v_i & ~reset_i) ? (num_req_p'(1) << resp_id) : '0;
  assign returned_yumi_o = returned_v_i & ~reset_i & resp_yumi_i[resp_id];
  assign resp_data_o     = returned_data_i;
  assign resp_reg_id_o   = {{lg_num_req_lp{1'b0}}, returned_reg_id_i[tag_lsb_lp-1:0]};

  always_comb begin
    loads_zero = 1'b1;
    for (int i = 0; i < num_req_p; i++)
      if (load_cnt[i] != '0) loads_zero = 1'b0;
  end

  assign credits_used_o = credits_used;
  assign idle_o         = loads_zero & (credits_used == '0) & ~|req_v_i;

  always @(posedge clk_i) begin
    if (!reset_i) begin
      if (returned_v_i) begin
        assert (load_cnt[resp_id] != '0)
          else $error("out_arbiter: response for requester %0d with no outstanding load", resp_id);
        assert (returned_pkt_type_i != e_return_credit)
          else $error("out_arbiter: credit return seen on returned_v_i");
      end
      if (handshake && is_load[grant_id])
        assert (req_pkt[grant_id].reg_id[bsg_manycore_reg_id_width_gp-1 -: lg_num_req_lp] == '0)
          else $error("out_arbiter: requester %0d load reg_id overlaps tag bits", grant_id);
    end
  end

endmodule

// File: tb/tb_bsg_manycore_endpoint_out_arbiter.sv
// tb/tb_bsg_manycore_endpoint_out_arbiter.sv - directed self-checking bench for the endpoint out arbiter
module tb_bsg_manycore_endpoint_out_arbiter;
  import bsg_manycore_pkg::*;

  localparam int N  = 4;
  localparam int XW = 4;
  localparam int YW = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int PW = AW + 2 + 5 + DW + 2 * (XW + YW);
  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_STORE = 2'd1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]    req_v, req_yumi, resp_v, resp_yumi;
  logic [N*PW-1:0] req_pkts;
  logic            out_v, out_ready, returned_v, returned_yumi, returned_credit_v, idle;
  logic [PW-1:0]   out_packet;
  logic [DW-1:0]   returned_data, resp_data;
  logic [4:0]      returned_reg_id, resp_reg_id;
  logic [4:0]      credits_used;
  bsg_manycore_return_packet_type_e ret_type;

  int n_checks = 0;
  int n_fail   = 0;

  bsg_manycore_endpoint_out_arbiter #(
    .num_req_p(N), .x_cord_width_p(XW), .y_cord_width_p(YW),
    .addr_width_p(AW), .data_width_p(DW),
    .max_out_credits_p(16), .max_loads_per_req_p(4)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .req_v_i(req_v), .req_packet_i(req_pkts), .req_yumi_o(req_yumi),
    .out_v_o(out_v), .out_packet_o(out_packet), .out_ready_i(out_ready),
    .returned_v_i(returned_v), .returned_data_i(returned_data),
    .returned_reg_id_i(returned_reg_id), .returned_pkt_type_i(ret_type),
    .returned_yumi_o(returned_yumi), .returned_credit_v_i(returned_credit_v),
    .resp_v_o(resp_v), .resp_data_o(resp_data), .resp_reg_id_o(resp_reg_id),
    .resp_yumi_i(resp_yumi),
    .credits_used_o(credits_used), .idle_o(idle)
  );

  function automatic logic [PW-1:0] mk(input logic [1:0] op, input logic [4:0] rid,
                                       input logic [AW-1:0] addr, input logic [DW-1:0] data);
    return {addr, op, rid, data, 4'h1, 4'h2, 4'h3, 4'h4};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic return_credits(input int n);
    returned_credit_v = 1'b1;
    repeat (n) next_cycle();
    returned_credit_v = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_v = '0; req_pkts = '0; out_ready = 1'b1;
    returned_v = 1'b0; returned_data = '0; returned_reg_id = '0; ret_type = e_return_int_wb;
    returned_credit_v = 1'b0; resp_yumi = '0;
    repeat (3) next_cycle();
    req_v = 4'b0001; req_pkts[0 +: PW] = mk(OP_STORE, 5'd0, 16'h0010, 32'h1);
    returned_v = 1'b1; resp_yumi = 4'b1111;
    @(negedge clk);
    n_checks++; if (req_yumi !== 4'b0000) begin n_fail++; $display("FAIL reset_req_yumi got %b want 0000", req_yumi); end
    n_checks++; if (returned_yumi !== 1'b0) begin n_fail++; $display("FAIL reset_returned_yumi got %b want 0", returned_yumi); end
    n_checks++; if (resp_v !== 4'b0000) begin n_fail++; $display("FAIL reset_resp_v got %b want 0000", resp_v); end
    next_cycle();
    reset = 1'b0; req_v = '0; returned_v = 1'b0; resp_yumi = '0;
    @(negedge clk);
    n_checks++; if (out_v !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_v got %b want 0", out_v); end
    n_checks++; if (req_yumi !== 4'b0000) begin n_fail++; $display("FAIL post_reset_yumi got %b want 0000", req_yumi); end
    n_checks++; if (returned_yumi !== 1'b0) begin n_fail++; $display("FAIL post_reset_returned_yumi got %b want 0", returned_yumi); end
    n_checks++; if (resp_v !== 4'b0000) begin n_fail++; $display("FAIL post_reset_resp_v got %b want 0000", resp_v); end
    n_checks++; if (credits_used !== 5'd0) begin n_fail++; $display("FAIL post_reset_credits got %0d want 0", credits_used); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL post_reset_idle got %b want 1", idle); end
    next_cycle();
  endtask

  task automatic test_round_robin();
    int exp_w [6] = '{0, 2, 0, 2, 0, 2};
    int rem [N] = '{3, 0, 3, 0};
    req_pkts[0*PW +: PW] = mk(OP_STORE, 5'd0, 16'h0100, 32'h000000A0);
    req_pkts[2*PW +: PW] = mk(OP_STORE, 5'd0, 16'h0200, 32'h000000C0);
    req_v = 4'b0101; out_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (out_v !== 1'b1) begin n_fail++; $display("FAIL rr_not_ready_out_v got %b want 1", out_v); end
    n_checks++; if (req_yumi !== 4'b0000) begin n_fail++; $display("FAIL rr_not_ready_yumi got %b want 0000", req_yumi); end
    next_cycle();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++; if (req_yumi !== (4'b0001 << exp_w[k])) begin n_fail++; $display("FAIL rr_grant_%0d got %b want %b", k, req_yumi, 4'b0001 << exp_w[k]); end
      if (k == 1) begin
        n_checks++; if (out_packet !== mk(OP_STORE, 5'd0, 16'h0200, 32'h000000C0)) begin n_fail++; $display("FAIL rr_store_passthru got %h", out_packet); end
      end
      next_cycle();
      rem[exp_w[k]]--;
      if (rem[exp_w[k]] == 0) req_v[exp_w[k]] = 1'b0;
    end
    @(negedge clk);
    n_checks++; if (credits_used !== 5'd6) begin n_fail++; $display("FAIL rr_credits got %0d want 6", credits_used); end
    n_checks++; if (out_v !== 1'b0) begin n_fail++; $display("FAIL rr_done_out_v got %b want 0", out_v); end
    next_cycle();
    return_credits(6);
    @(negedge clk);
    n_checks++; if (credits_used !== 5'd0) begin n_fail++; $display("FAIL rr_drain_credits got %0d want 0", credits_used); end
    next_cycle();
  endtask

  task automatic test_credit_limit();
    int grants = 0;
    req_pkts[0*PW +: PW] = mk(OP_STORE, 5'd0, 16'h0110, 32'h5);
    req_v = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (req_yumi === 4'b0001) grants++;
      next_cycle();
    end
    n_checks++; if (grants !== 16) begin n_fail++; $display("FAIL cl_grant_count got %0d want 16", grants); end
    @(negedge clk);
    n_checks++; if (out_v !== 1'b0) begin n_fail++; $display("FAIL cl_full_out_v got %b want 0", out_v); end
    n_checks++; if (credits_used !== 5'd16) begin n_fail++; $display("FAIL cl_full_credits got %0d want 16", credits_used); end
    next_cycle();
    returned_credit_v = 1'b1;
    @(negedge clk);
    n_checks++; if (out_v !== 1'b0) begin n_fail++; $display("FAIL cl_same_cycle_return_out_v got %b want 0", out_v); end
    next_cycle();
    returned_credit_v = 1'b0;
    @(negedge clk);
    n_checks++; if (req_yumi !== 4'b0001) begin n_fail++; $display("FAIL cl_one_grant got %b want 0001", req_yumi); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (out_v !== 1'b0) begin n_fail++; $display("FAIL cl_refull_out_v got %b want 0", out_v); end
    n_checks++; if (credits_used !== 5'd16) begin n_fail++; $display("FAIL cl_refull_credits got %0d want 16", credits_used); end
    next_cycle();
    req_v = '0;
    return_credits(16);
  endtask

  task automatic test_load_limit();
    req_pkts[1*PW +: PW] = mk(OP_LOAD, 5'b00010, 16'h0300, 32'h0);
    req_v = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++; if (req_yumi !== 4'b0010) begin n_fail++; $display("FAIL ll_load_%0d got %b want 0010", k, req_yumi); end
      if (k == 0) begin
        n_checks++; if (out_packet !== mk(OP_LOAD, 5'b01010, 16'h0300, 32'h0)) begin n_fail++; $display("FAIL ll_tag_req1 got %h", out_packet); end
      end
      next_cycle();
    end
    @(negedge clk);
    n_checks++; if (out_v !== 1'b0) begin n_fail++; $display("FAIL ll_fifth_held got %b want 0", out_v); end
    next_cycle();
    req_pkts[3*PW +: PW] = mk(OP_STORE, 5'd0, 16'h0400, 32'h33);
    req_v = 4'b1010;
    @(negedge clk);
    n_checks++; if (req_yumi !== 4'b1000) begin n_fail++; $display("FAIL ll_store_bypass got %b want 1000", req_yumi); end
    n_checks++; if (out_packet !== mk(OP_STORE, 5'd0, 16'h0400, 32'h33)) begin n_fail++; $display("FAIL ll_store_packet got %h", out_packet); end
    next_cycle();
    req_v = 4'b0010; returned_v = 1'b1; returned_reg_id = 5'b01010; returned_data = 32'h11; resp_yumi = 4'b0010;
    @(negedge clk);
    n_checks++; if (resp_v !== 4'b0010) begin n_fail++; $display("FAIL ll_resp_v got %b want 0010", resp_v); end
    n_checks++; if (returned_yumi !== 1'b1) begin n_fail++; $display("FAIL ll_returned_yumi got %b want 1", returned_yumi); end
    n_checks++; if (out_v !== 1'b0) begin n_fail++; $display("FAIL ll_return_same_cycle got %b want 0", out_v); end
    next_cycle();
    returned_v = 1'b0; resp_yumi = '0;
    @(negedge clk);
    n_checks++; if (req_yumi !== 4'b0010) begin n_fail++; $display("FAIL ll_slot_freed got %b want 0010", req_yumi); end
    next_cycle();
    req_v = '0; returned_v = 1'b1; resp_yumi = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++; if (returned_yumi !== 1'b1) begin n_fail++; $display("FAIL ll_drain_%0d got %b want 1", k, returned_yumi); end
      next_cycle();
    end
    returned_v = 1'b0; resp_yumi = '0;
    return_credits(6);
    @(negedge clk);
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL ll_idle got %b want 1", idle); end
    next_cycle();
  endtask

  task automatic test_tag_and_hold();
    req_pkts[3*PW +: PW] = mk(OP_LOAD, 5'b00101, 16'h0500, 32'h0);
    req_v = 4'b1000;
    @(negedge clk);
    n_checks++; if (req_yumi !== 4'b1000) begin n_fail++; $display("FAIL tag_grant got %b want 1000", req_yumi); end
    n_checks++; if (out_packet !== mk(OP_LOAD, 5'b11101, 16'h0500, 32'h0)) begin n_fail++; $display("FAIL tag_packet got %h", out_packet); end
    next_cycle();
    req_v = '0;
    return_credits(1);
    returned_v = 1'b1; returned_reg_id = 5'b11101; returned_data = 32'hDEADBEEF; resp_yumi = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (resp_v !== 4'b1000) begin n_fail++; $display("FAIL hold_resp_v_%0d got %b want 1000", k, resp_v); end
      n_checks++; if (resp_reg_id !== 5'b00101) begin n_fail++; $display("FAIL hold_reg_id_%0d got %b want 00101", k, resp_reg_id); end
      n_checks++; if (returned_yumi !== 1'b0) begin n_fail++; $display("FAIL hold_yumi_%0d got %b want 0", k, returned_yumi); end
      n_checks++; if (idle !== 1'b0) begin n_fail++; $display("FAIL hold_load_pending_%0d got %b want 0", k, idle); end
      next_cycle();
    end
    resp_yumi = 4'b1000;
    @(negedge clk);
    n_checks++; if (returned_yumi !== 1'b1) begin n_fail++; $display("FAIL hold_release got %b want 1", returned_yumi); end
    n_checks++; if (resp_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hold_data got %h want deadbeef", resp_data); end
    next_cycle();
    returned_v = 1'b0; resp_yumi = '0;
    @(negedge clk);
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL hold_idle_after got %b want 1", idle); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    req_pkts[0*PW +: PW] = mk(OP_STORE, 5'd0, 16'h0600, 32'h66);
    req_v = 4'b0001;
    repeat (5) next_cycle();
    req_v = '0;
    @(negedge clk);
    n_checks++; if (credits_used !== 5'd5) begin n_fail++; $display("FAIL rm_before got %0d want 5", credits_used); end
    next_cycle();
    reset = 1'b1; req_v = 4'b0001;
    @(negedge clk);
    n_checks++; if (req_yumi !== 4'b0000) begin n_fail++; $display("FAIL rm_yumi_forced got %b want 0000", req_yumi); end
    next_cycle();
    reset = 1'b0; req_v = '0;
    @(negedge clk);
    n_checks++; if (credits_used !== 5'd0) begin n_fail++; $display("FAIL rm_credits got %0d want 0", credits_used); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rm_idle got %b want 1", idle); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_credit_limit();
    test_load_limit();
    test_tag_and_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_manycore_endpoint_out_arbiter.md
# bsg_manycore_endpoint_out_arbiter

Shares one manycore endpoint master port (out_request plus in_response groups) among `num_req_p` local requesters. It performs round-robin arbitration of outgoing request packets and enforces a global outstanding-credit limit and a per-requester outstanding-load limit. It tags remote loads with the requester index in the upper reg_id bits and steers returned load data back to the issuing requester. It sits between several tile-local masters (DMA, accelerator lanes) and a single `bsg_manycore_endpoint_standard` instance.

## Interface
Parameters:
- `num_req_p`, 4 — requester count, power of two, 2..8.
- `x_cord_width_p`, `y_cord_width_p`, `addr_width_p`, `data_width_p` — no default; same meaning as the endpoint.
- `max_out_credits_p`, 16 — global outstanding request limit.
- `max_loads_per_req_p`, 4 — outstanding loads per requester.
- `lg_num_req_lp` (local) — `$clog2(num_req_p)`.
- `tag_lsb_lp` (local) — `bsg_manycore_reg_id_width_gp - lg_num_req_lp`.

Ports (clock and reset: one clock; reset is synchronous and active-high):
- `clk_i` in 1 — clock.
- `reset_i` in 1 — synchronous, active-high reset.
- `req_v_i` in `num_req_p` — requester packet valid.
- `req_packet_i` in `num_req_p`×packet_width — `bsg_manycore_packet_s` per requester.
- `req_yumi_o` out `num_req_p` — packet accepted this cycle.
- `out_v_o` out 1 — to endpoint `out_v_i`.
- `out_packet_o` out packet_width — to endpoint `out_packet_i`.
- `out_ready_i` in 1 — from endpoint `out_credit_or_ready_o` (ready mode).
- `returned_v_i`, `returned_data_i`, `returned_reg_id_i`, `returned_pkt_type_i` in — from the endpoint in_response group.
- `returned_yumi_o` out 1 — to the endpoint.
- `returned_credit_v_i` in 1 — from the endpoint; one return consumed.
- `resp_v_o` out `num_req_p` — load data valid per requester.
- `resp_data_o` out data_width — shared data bus.
- `resp_reg_id_o` out `bsg_manycore_reg_id_width_gp` — returned reg_id with the tag bits zeroed.
- `resp_yumi_i` in `num_req_p` — requester consumes the response.
- `credits_used_o` out `$clog2(max_out_credits_p+1)` — global outstanding count.
- `idle_o` out 1 — asserted when all counters are zero and no `req_v_i` is high.

## Operation
- Eligibility of requester i:
  - `req_v_i[i]` is high.
  - `credits_used < max_out_credits_p`.
  - If its packet `op_v2 == e_remote_load`, then `load_cnt[i] < max_loads_per_req_p`.
- Grant:
  - At most one grant per cycle.
  - Round-robin among eligible requesters, starting at `rr_ptr`.
  - `out_v_o` is high when any requester is eligible. `req_yumi_o[w] = out_v_o & out_ready_i`.
  - On a handshake, `rr_ptr <= w+1` (mod `num_req_p`). With no handshake, `rr_ptr` holds.
  - The grant is combinational (`out_v_o` depends on `req_v_i`). Requesters must hold the packet until yumi.
- Load tagging: for loads, `out_packet_o.reg_id[reg_id_width-1 -: lg_num_req_lp] = w`. The lower `tag_lsb_lp` bits pass through from the requester. All other packet fields and ops pass through unchanged.
- Requester constraint: requester load reg_ids must fit in `tag_lsb_lp` bits. A simulation assertion fires on violation.
- Counters:
  - `credits_used` increments on an out handshake and decrements on `returned_credit_v_i`. On simultaneous increment and decrement it is unchanged.
  - `load_cnt[i]` increments on a load handshake from i and decrements on a response handshake to i.
- Response steering:
  - `id = returned_reg_id_i` upper `lg_num_req_lp` bits.
  - `resp_v_o[id] = returned_v_i`; all other `resp_v_o` bits are low.
  - `returned_yumi_o = returned_v_i & resp_yumi_i[id]`.
  - Credit-type returns never appear on `returned_v_i`; the endpoint absorbs them.
- Errors (simulation only, `$error`):
  - counter underflow;
  - counter overflow;
  - `returned_v_i` with `load_cnt[id]==0`.

## Timing
- Reset values:
  - `rr_ptr=0`, `credits_used=0`, all `load_cnt=0`.
  - Outputs: `out_v_o=0` (no valid inputs during reset), `req_yumi_o=0`, `returned_yumi_o=0`, `resp_v_o=0`, `credits_used_o=0`, `idle_o=1`.
  - During reset all yumis are forced to 0.
- Request path: zero-cycle, combinational from `req_v_i`/`out_ready_i` to `out_v_o`/`req_yumi_o`.
- Response path: zero-cycle, combinational from `returned_*` to `resp_*`.
- Counters update at the clock edge after the handshake. Eligibility sees the registered counts only, so a decrement frees a slot the following cycle.
- Full boundary: at `credits_used == max_out_credits_p`, `out_v_o=0` even if a credit returns the same cycle.
- Reset mid-operation clears all counters. Any responses still in flight afterwards are a system error.

## Configuration
- `BSG_MANYCORE_OUT_ARB_FIXED_PRIO_EN` defined: fixed priority, with the lowest index winning. `rr_ptr` is removed.
- Macro undefined (default): round-robin as described above.

## Structure
- Package `bsg_manycore_pkg`: add `bsg_manycore_arb_tag_width_gp` and a helper function that extracts the tag from a reg_id.
- Sub-module: `bsg_arb_round_robin` (basejump_stl), used for grant selection with `yumi_i` = handshake. Replaced by `bsg_priority_encode` under the macro.
- Counters: `bsg_counter_up_down`, one per requester plus one global.

## Test plan
- Requesters 0 and 2 each hold 3 stores, `out_ready_i=1` -> grants alternate 0,2,0,2,0,2; `credits_used_o` reaches 6.
- `max_out_credits_p=16` reached with no returns -> `out_v_o=0`. One `returned_credit_v_i` pulse -> exactly one grant on the next cycle.
- Requester 1 issues 4 loads (`max_loads_per_req_p=4`) -> the 5th load is held while requester 3's store is still granted.
- Load from requester 3 with reg_id 5'b00101, `num_req_p=4` -> `out_packet_o.reg_id=5'b11101`. The return with reg_id 5'b11101 -> `resp_v_o=4'b1000`, `resp_reg_id_o=5'b00101`.
- `resp_yumi_i=0` for 3 cycles -> `returned_yumi_o=0` for those cycles; `load_cnt` is unchanged until yumi.
- Reset asserted with 5 outstanding -> the next cycle shows `credits_used_o=0`, `idle_o=1`.
